// File: rtl/drop_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : drop_board_ctrl
// Purpose : Column-drop board controller with cursor, per-column heights,
//           turn alternation and a valid/ready handshake to a move engine.
// Rev     : 1.0  initial release
// ============================================================================
module drop_board_ctrl #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter bit WRAP = 1'b0,
  localparam int CW = $clog2(COLS),
  localparam int HW = $clog2(ROWS + 1),
  localparam int RW = $clog2(ROWS),
  localparam int NW = $clog2(COLS * ROWS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     left,
  input  logic                     right,
  input  logic                     middle,
  input  logic                     ai_en,
  input  logic                     term,
  input  logic                     ai_valid,
  input  logic [CW-1:0]            ai_col,
  output logic                     ai_ready,
  output logic [2*COLS*ROWS-1:0]   board,
  output logic [COLS*HW-1:0]       heights,
  output logic [CW-1:0]            cursor,
  output logic                     player,
  output logic                     last_valid,
  output logic [RW-1:0]            last_row,
  output logic [CW-1:0]            last_col,
  output logic                     rejected,
  output logic                     full
);

  localparam logic [CW-1:0] C_LAST  = CW'(COLS - 1);
  localparam logic [HW-1:0] C_ROWS  = HW'(ROWS);
  localparam logic [NW-1:0] C_CELLS = NW'(COLS * ROWS);

  typedef enum logic [1:0] {
    S_HUMAN = 2'd0,
    S_AI    = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_left_q, r_right_q, r_mid_q;
  logic [HW-1:0]   r_heights [COLS];
  logic [1:0]      r_cell [ROWS][COLS];
  logic [NW-1:0]   r_count;
  logic [CW-1:0]   r_cursor, w_cursor_nxt;
  logic            r_player, r_last_valid, r_rejected;
  logic [RW-1:0]   r_last_row;
  logic [CW-1:0]   r_last_col;

  logic            w_left_edge, w_right_edge, w_mid_edge;
  logic            w_commit, w_reject, w_set_p2, w_room;
  logic [CW-1:0]   w_col;
  logic [HW-1:0]   w_col_h;

  assign w_left_edge  = left   & ~r_left_q;
  assign w_right_edge = right  & ~r_right_q;
  assign w_mid_edge   = middle & ~r_mid_q;

  assign full     = (r_count == C_CELLS);
  assign ai_ready = (r_state == S_AI) && !term && !full;
  assign w_col    = (r_state == S_AI) ? ai_col : r_cursor;
  assign w_room   = (w_col_h < C_ROWS);

  // A column index beyond the board reads as full, so it is rejected like a full column.
  always_comb begin
    w_col_h = C_ROWS;
    for (int c = 0; c < COLS; c++) begin
      if (w_col == CW'(c)) w_col_h = r_heights[c];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_HUMAN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_commit     = 1'b0;
    w_reject     = 1'b0;
    w_set_p2     = 1'b0;
    w_cursor_nxt = r_cursor;
    case (r_state)
      S_HUMAN: begin
        if (term || full) begin
          w_state_nxt = S_LOCK;
        end else if (w_mid_edge) begin
          if (w_room) begin
            w_commit = 1'b1;
            if (!r_player && ai_en) w_state_nxt = S_AI;
          end else begin
            w_reject = 1'b1;
          end
        end else if (w_left_edge && !w_right_edge) begin
          if (r_cursor != '0) w_cursor_nxt = r_cursor - CW'(1);
          else if (WRAP)      w_cursor_nxt = C_LAST;
        end else if (w_right_edge && !w_left_edge) begin
          if (r_cursor != C_LAST) w_cursor_nxt = r_cursor + CW'(1);
          else if (WRAP)          w_cursor_nxt = '0;
        end
      end
      S_AI: begin
        if (term || full) begin
          w_state_nxt = S_LOCK;
        end else if (ai_valid) begin
          if (w_room) begin
            w_commit    = 1'b1;
            w_state_nxt = S_HUMAN;
          end else begin
            w_reject = 1'b1;
          end
        end else if (!ai_en) begin
          w_state_nxt = S_HUMAN;
          w_set_p2    = 1'b1;
        end
      end
      S_LOCK: begin
        if (!full && !term) w_state_nxt = (r_player && ai_en) ? S_AI : S_HUMAN;
      end
      default: w_state_nxt = S_HUMAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_left_q     <= 1'b0;
      r_right_q    <= 1'b0;
      r_mid_q      <= 1'b0;
      r_cursor     <= '0;
      r_player     <= 1'b0;
      r_count      <= '0;
      r_last_valid <= 1'b0;
      r_rejected   <= 1'b0;
      r_last_row   <= '0;
      r_last_col   <= '0;
    end else begin
      r_left_q     <= left;
      r_right_q    <= right;
      r_mid_q      <= middle;
      r_cursor     <= w_cursor_nxt;
      r_last_valid <= w_commit;
      r_rejected   <= w_reject;
      if (w_commit) begin
        r_player   <= ~r_player;
        r_count    <= r_count + NW'(1);
        r_last_row <= w_col_h[RW-1:0];
        r_last_col <= w_col;
      end else if (w_set_p2) begin
        r_player <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             r_heights[c] <= '0;
      else if (w_commit && w_col == CW'(c)) r_heights[c] <= r_heights[c] + HW'(1);
    end
    assign heights[c*HW +: HW] = r_heights[c];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          r_cell[r][c] <= 2'b00;
        else if (w_commit && w_col == CW'(c) && w_col_h == HW'(r))
          r_cell[r][c] <= r_player ? 2'b10 : 2'b01;
      end
      assign board[2*(r*COLS+c) +: 2] = r_cell[r][c];
    end
  end

  assign cursor     = r_cursor;
  assign player     = r_player;
  assign last_valid = r_last_valid;
  assign last_row   = r_last_row;
  assign last_col   = r_last_col;
  assign rejected   = r_rejected;

endmodule
`default_nettype wire
